mm_reg_arbiter: RTL and testbench
=================================

MM_REG_ARBITER -- requirements
Module: mm_reg_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 4, SHALL be the word-address width on all ports.
REQ-002 Parameter N_MASTERS, default 2, range 2..8, SHALL be the number of upstream Avalon-MM masters.
REQ-003 Parameter TIMEOUT, default 2048, SHALL be the watchdog limit in mm_clk cycles per transaction.
REQ-004 Ports SHALL be:
 rst  in  1  reset, asynchronous, active-high
 mm_clk  in  1  clock for all logic
 m_address  in  [N_MASTERS][ADDR_SIZE]  per-master word address
 m_read / m_write  in  [N_MASTERS]  per-master commands
 m_writedata  in  [N_MASTERS][32]  per-master write data
 m_byteenable  in  [N_MASTERS][4]  per-master byte enables
 m_waitrequest  out  [N_MASTERS]  per-master stall, low for exactly one cycle on acceptance
 m_readdata  out  [N_MASTERS][32]  per-master read data
 m_readdatavalid  out  [N_MASTERS]  per-master read-response strobe
 s_address  out  ADDR_SIZE  to shared register slave
 s_read / s_write  out  1  slave commands, registered
 s_writedata  out  32  slave write data, registered
 s_byteenable  out  4  slave byte enables, registered
 s_waitrequest  in  1  slave stall
 s_readdata  in  32  slave read data
 s_readdatavalid  in  1  slave read-response strobe
 grant_id  out  $clog2(N_MASTERS)  index of current/last granted master
 busy  out  1  high while state is not IDLE
 timeout_count  out  8  saturating count of watchdog expiries

Function
REQ-005 States: IDLE, ISSUE, READ_WAIT, RESP; one transaction in flight at a time; burstcount fixed at 1.
REQ-006 A master requests when m_read or m_write is high; if both are high, write SHALL take precedence.
REQ-007 In IDLE with any request, arbiter SHALL grant by round robin starting at (last_grant+1) mod N_MASTERS, latch that master's address/writedata/byteenable/command into s_* and enter ISSUE next cycle.
REQ-008 In ISSUE, s_read or s_write SHALL stay high until a cycle with s_waitrequest low, then drop the following cycle.
REQ-009 On slave acceptance of a write, m_waitrequest[grant] SHALL go low for one cycle and state SHALL return to IDLE.
REQ-010 On slave acceptance of a read, m_waitrequest[grant] SHALL go low for one cycle and state SHALL enter READ_WAIT.
REQ-011 In READ_WAIT, on s_readdatavalid, m_readdata[grant] SHALL be loaded with s_readdata and m_readdatavalid[grant] pulsed for one cycle (state RESP), then IDLE.
REQ-012 Grant-to-response latency SHALL be slave latency plus 2 cycles; no combinational path from m_* to s_*.
REQ-013 Non-granted masters SHALL see m_waitrequest high and m_readdatavalid low throughout.
REQ-014 Watchdog counter SHALL clear on grant and increment in ISSUE and READ_WAIT; on reaching TIMEOUT, s_read/s_write drop, write completes per REQ-009, read completes per REQ-011 with data 32'hFFFFFFFF, timeout_count increments (saturates at 255).
REQ-015 s_readdatavalid or s_waitrequest-low outside ISSUE/READ_WAIT (late response after timeout) SHALL be ignored.
REQ-016 Partial byteenable SHALL be forwarded unchanged; the arbiter SHALL NOT filter it.
REQ-017 A master reasserting a command in the cycle after acceptance SHALL only be regranted after every other requesting master has been served once.

Reset
REQ-018 rst SHALL force state IDLE, last_grant = N_MASTERS-1 (master 0 wins first), grant_id 0, watchdog 0, timeout_count 0.
REQ-019 During/after reset: all m_waitrequest high, m_readdatavalid 0, m_readdata 0, s_read 0, s_write 0, s_address/s_writedata/s_byteenable 0, busy 0.
REQ-020 Reset mid-transaction SHALL abort it with no response to any master.

Structure
REQ-021 State enum, default TIMEOUT and the 32'hFFFFFFFF timeout read value SHALL live in shared package la_pkg.
REQ-022 Round-robin selection SHALL be one sub-module rr_select (request vector + last grant in, one-hot/index out, combinational).

Verification
REQ-023 Master 0 writes 0x12345678 to addr 3, slave waitrequest 2 cycles -> s_write high 3 cycles, m_waitrequest[0] low one cycle, state IDLE.
REQ-024 Masters 0 and 1 read simultaneously, slave readdata 0xA5 then 0x5A -> master 0 gets 0xA5 first, master 1 gets 0x5A, one readdatavalid each.
REQ-025 Master 1 issues back-to-back reads while master 0 holds a read -> grants alternate 0,1,0,1.
REQ-026 Slave never responds to a read, TIMEOUT=16 -> readdatavalid with 0xFFFFFFFF after ~18 cycles, timeout_count=1; late s_readdatavalid ignored.
REQ-027 rst asserted in READ_WAIT -> all outputs at reset values next edge, no m_readdatavalid pulse.
REQ-028 Master with m_read and m_write both high -> s_write issued, s_read stays 0.

Source files
------------

// File: rtl/la_pkg.sv
// Shared types and constants for the Avalon-MM register arbiter.
package la_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        READ_WAIT,
        RESP
    } la_state_e;

    localparam int          LA_DEFAULT_TIMEOUT = 2048;
    localparam logic [31:0] LA_TIMEOUT_DATA    = 32'hFFFF_FFFF;

    function automatic logic [7:0] la_sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: searches from (last + 1) mod N upward.
module rr_select #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    always_comb begin
        int cand;
        cand         = 0;
        grant_onehot = '0;
        grant_idx    = '0;
        any          = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand = (int'(last) + i) % N;
            if (!any && req[IW'(cand)]) begin
                any                       = 1'b1;
                grant_onehot[IW'(cand)]   = 1'b1;
                grant_idx                 = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/mm_reg_arbiter.sv
// N-master to one-slave Avalon-MM arbiter with round-robin grant,
// one transaction in flight, and a per-transaction watchdog.
module mm_reg_arbiter
    import la_pkg::*;
#(
    parameter int ADDR_SIZE = 4,
    parameter int N_MASTERS = 2,
    parameter int TIMEOUT   = LA_DEFAULT_TIMEOUT
) (
    input  logic                                rst,
    input  logic                                mm_clk,
    input  logic [N_MASTERS-1:0][ADDR_SIZE-1:0] m_address,
    input  logic [N_MASTERS-1:0]                m_read,
    input  logic [N_MASTERS-1:0]                m_write,
    input  logic [N_MASTERS-1:0][31:0]          m_writedata,
    input  logic [N_MASTERS-1:0][3:0]           m_byteenable,
    output logic [N_MASTERS-1:0]                m_waitrequest,
    output logic [N_MASTERS-1:0][31:0]          m_readdata,
    output logic [N_MASTERS-1:0]                m_readdatavalid,
    output logic [ADDR_SIZE-1:0]                s_address,
    output logic                                s_read,
    output logic                                s_write,
    output logic [31:0]                         s_writedata,
    output logic [3:0]                          s_byteenable,
    input  logic                                s_waitrequest,
    input  logic [31:0]                         s_readdata,
    input  logic                                s_readdatavalid,
    output logic [$clog2(N_MASTERS)-1:0]        grant_id,
    output logic                                busy,
    output logic [7:0]                          timeout_count
);

    localparam int              IDX_W   = $clog2(N_MASTERS);
    localparam int              WD_W    = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    la_state_e            state;
    logic [IDX_W-1:0]     last_grant;
    logic [WD_W-1:0]      wdog;
    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] req_masked;
    logic [N_MASTERS-1:0] sel_onehot;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_any;
    logic                 sel_write;
    logic                 wd_expired;

    assign req = m_read | m_write;
    // The just-accepted master still holds its command during the ack cycle.
    assign req_masked = req & m_waitrequest;
    assign sel_write  = |(sel_onehot & m_write);
    assign wd_expired = (wdog >= WD_LAST);
    assign busy       = (state != IDLE);

    rr_select #(
        .N  (N_MASTERS),
        .IW (IDX_W)
    ) u_rr_select (
        .req          (req_masked),
        .last         (last_grant),
        .grant_onehot (sel_onehot),
        .grant_idx    (sel_idx),
        .any          (sel_any)
    );

    always_ff @(posedge mm_clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last_grant      <= IDX_W'(N_MASTERS - 1);
            grant_id        <= '0;
            wdog            <= '0;
            timeout_count   <= '0;
            m_waitrequest   <= '1;
            m_readdata      <= '0;
            m_readdatavalid <= '0;
            s_address       <= '0;
            s_read          <= 1'b0;
            s_write         <= 1'b0;
            s_writedata     <= '0;
            s_byteenable    <= '0;
        end else begin
            m_waitrequest   <= '1;
            m_readdatavalid <= '0;
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        grant_id     <= sel_idx;
                        last_grant   <= sel_idx;
                        wdog         <= '0;
                        s_address    <= m_address[sel_idx];
                        s_writedata  <= m_writedata[sel_idx];
                        s_byteenable <= m_byteenable[sel_idx];
                        s_write      <= sel_write;
                        s_read       <= ~sel_write;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog <= wdog + 1'b1;
                    if (!s_waitrequest || wd_expired) begin
                        s_read                  <= 1'b0;
                        s_write                 <= 1'b0;
                        m_waitrequest[grant_id] <= 1'b0;
                        if (s_write) begin
                            state <= IDLE;
                        end else if (!s_waitrequest) begin
                            state <= READ_WAIT;
                        end else begin
                            // Read never accepted: complete it straight away with the error word.
                            m_readdata[grant_id]      <= LA_TIMEOUT_DATA;
                            m_readdatavalid[grant_id] <= 1'b1;
                            state                     <= RESP;
                        end
                        if (s_waitrequest) begin
                            timeout_count <= la_sat_inc(timeout_count);
                        end
                    end
                end
                READ_WAIT: begin
                    wdog <= wdog + 1'b1;
                    if (s_readdatavalid) begin
                        m_readdata[grant_id]      <= s_readdata;
                        m_readdatavalid[grant_id] <= 1'b1;
                        state                     <= RESP;
                    end else if (wd_expired) begin
                        m_readdata[grant_id]      <= LA_TIMEOUT_DATA;
                        m_readdatavalid[grant_id] <= 1'b1;
                        timeout_count             <= la_sat_inc(timeout_count);
                        state                     <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_reg_arbiter.sv
// Self-checking bench for mm_reg_arbiter: table of single-master transactions
// plus hand-written multi-master, timeout and reset sequences.
module tb_mm_reg_arbiter;

    localparam int AW = 4;
    localparam int NM = 2;
    localparam int TO = 16;

    logic                    rst;
    logic                    mm_clk;
    logic [NM-1:0][AW-1:0]   m_address;
    logic [NM-1:0]           m_read;
    logic [NM-1:0]           m_write;
    logic [NM-1:0][31:0]     m_writedata;
    logic [NM-1:0][3:0]      m_byteenable;
    logic [NM-1:0]           m_waitrequest;
    logic [NM-1:0][31:0]     m_readdata;
    logic [NM-1:0]           m_readdatavalid;
    logic [AW-1:0]           s_address;
    logic                    s_read;
    logic                    s_write;
    logic [31:0]             s_writedata;
    logic [3:0]              s_byteenable;
    logic                    s_waitrequest;
    logic [31:0]             s_readdata;
    logic                    s_readdatavalid;
    logic [0:0]              grant_id;
    logic                    busy;
    logic [7:0]              timeout_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          master;
        logic        rd;
        logic        wr;
        logic [AW-1:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          s_wait;
        int          s_lat;
        logic [31:0] rdata;
        int          exp_wr_cyc;
        int          exp_rd_cyc;
        int          exp_ack_cyc;
        int          exp_valid_cyc;
        logic [31:0] exp_rdata;
        int          exp_tcount;
    } vec_t;

    vec_t vecs [8];

    logic [31:0] rdata_q [$];
    logic [31:0] got0_q  [$];
    logic [31:0] got1_q  [$];
    int          order_q [$];

    mm_reg_arbiter #(
        .ADDR_SIZE (AW),
        .N_MASTERS (NM),
        .TIMEOUT   (TO)
    ) dut (
        .rst             (rst),
        .mm_clk          (mm_clk),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .s_address       (s_address),
        .s_read          (s_read),
        .s_write         (s_write),
        .s_writedata     (s_writedata),
        .s_byteenable    (s_byteenable),
        .s_waitrequest   (s_waitrequest),
        .s_readdata      (s_readdata),
        .s_readdatavalid (s_readdatavalid),
        .grant_id        (grant_id),
        .busy            (busy),
        .timeout_count   (timeout_count)
    );

    initial begin
        mm_clk = 1'b0;
        forever #5 mm_clk = ~mm_clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL sim_timeout: simulation did not finish within time limit");
        $fatal(1, "[TB] time limit");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_m_waitrequest"},   32'(m_waitrequest),   32'h3);
        check_output({tag, "_m_readdatavalid"}, 32'(m_readdatavalid), 32'h0);
        check_output({tag, "_m_readdata0"},     m_readdata[0],        32'h0);
        check_output({tag, "_m_readdata1"},     m_readdata[1],        32'h0);
        check_output({tag, "_s_cmd"},           32'({s_read, s_write}), 32'h0);
        check_output({tag, "_s_address"},       32'(s_address),       32'h0);
        check_output({tag, "_s_writedata"},     s_writedata,          32'h0);
        check_output({tag, "_s_byteenable"},    32'(s_byteenable),    32'h0);
        check_output({tag, "_busy"},            32'(busy),            32'h0);
        check_output({tag, "_grant_id"},        32'(grant_id),        32'h0);
        check_output({tag, "_timeout_count"},   32'(timeout_count),   32'h0);
    endtask

    // One master, one transaction, a scripted slave; 24-cycle observation window.
    task automatic apply_vector(input int idx, input vec_t v);
        int          other;
        int          wait_left;
        int          lat_left;
        bit          resp_armed;
        bit          drop_pending;
        bit          seen_cmd;
        int          wr_cyc, rd_cyc, acks, valids, other_bad;
        int          ack_cyc, valid_cyc, complete_cyc;
        logic [AW-1:0] cap_addr;
        logic [31:0] cap_wdata, got_data;
        logic [3:0]  cap_be;
        logic [0:0]  cap_gid;
        string       p;

        other = (v.master == 0) ? 1 : 0;
        wait_left = v.s_wait; lat_left = 0; resp_armed = 0; drop_pending = 0; seen_cmd = 0;
        wr_cyc = 0; rd_cyc = 0; acks = 0; valids = 0; other_bad = 0;
        ack_cyc = -1; valid_cyc = -1; complete_cyc = -1;
        cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_gid = '0; got_data = '0;
        p = $sformatf("v%0d", idx);

        @(negedge mm_clk);
        m_address[v.master]    = v.addr;
        m_writedata[v.master]  = v.wdata;
        m_byteenable[v.master] = v.be;
        m_read[v.master]       = v.rd;
        m_write[v.master]      = v.wr;
        s_waitrequest          = 1'b1;
        s_readdatavalid        = 1'b0;

        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge mm_clk);
            if (drop_pending) begin
                m_read[v.master]  = 1'b0;
                m_write[v.master] = 1'b0;
                drop_pending      = 0;
            end
            if (s_read)  rd_cyc++;
            if (s_write) wr_cyc++;
            if ((s_read || s_write) && !seen_cmd) begin
                seen_cmd  = 1;
                cap_addr  = s_address;
                cap_wdata = s_writedata;
                cap_be    = s_byteenable;
                cap_gid   = grant_id;
            end
            if (!m_waitrequest[v.master]) begin
                acks++;
                if (ack_cyc < 0) ack_cyc = cyc;
                drop_pending = 1;
                if (!(v.rd && !v.wr) && complete_cyc < 0) complete_cyc = cyc;
            end
            if (m_readdatavalid[v.master]) begin
                valids++;
                if (valid_cyc < 0) valid_cyc = cyc;
                got_data = m_readdata[v.master];
                if (complete_cyc < 0) complete_cyc = cyc;
            end
            if (!m_waitrequest[other] || m_readdatavalid[other]) other_bad++;

            if (s_read || s_write) begin
                if (wait_left > 0) begin
                    s_waitrequest = 1'b1;
                    wait_left--;
                end else begin
                    s_waitrequest = 1'b0;
                    if (s_read) begin
                        lat_left   = v.s_lat;
                        resp_armed = 1;
                    end
                end
                s_readdatavalid = 1'b0;
            end else begin
                s_waitrequest = 1'b1;
                if (resp_armed && lat_left == 0) begin
                    s_readdatavalid = 1'b1;
                    s_readdata      = v.rdata;
                    resp_armed      = 0;
                end else begin
                    s_readdatavalid = 1'b0;
                    if (resp_armed && lat_left > 0) lat_left--;
                end
            end
            // Late, unsolicited slave response once the transaction is over.
            if (complete_cyc >= 0 && cyc == complete_cyc + 2) begin
                s_readdatavalid = 1'b1;
                s_readdata      = 32'h1357_9BDF;
                s_waitrequest   = 1'b0;
            end
        end
        m_read          = '0;
        m_write         = '0;
        s_readdatavalid = 1'b0;
        s_waitrequest   = 1'b1;

        check_output({p, "_s_address"},    32'(cap_addr),   32'(v.addr));
        check_output({p, "_s_writedata"},  cap_wdata,       v.wdata);
        check_output({p, "_s_byteenable"}, 32'(cap_be),     32'(v.be));
        check_output({p, "_grant_id"},     32'(cap_gid),    32'(v.master));
        check_output({p, "_s_write_cyc"},  32'(wr_cyc),     32'(v.exp_wr_cyc));
        check_output({p, "_s_read_cyc"},   32'(rd_cyc),     32'(v.exp_rd_cyc));
        check_output({p, "_acks"},         32'(acks),       32'd1);
        check_output({p, "_ack_cyc"},      32'(ack_cyc),    32'(v.exp_ack_cyc));
        check_output({p, "_valids"},       32'(valids),     (v.exp_valid_cyc >= 0) ? 32'd1 : 32'd0);
        check_output({p, "_valid_cyc"},    32'(valid_cyc),  32'(v.exp_valid_cyc));
        if (v.exp_valid_cyc >= 0)
            check_output({p, "_readdata"}, got_data,        v.exp_rdata);
        check_output({p, "_other_quiet"},  32'(other_bad),  32'd0);
        check_output({p, "_busy_end"},     32'(busy),       32'd0);
        check_output({p, "_timeout_count"}, 32'(timeout_count), 32'(v.exp_tcount));
    endtask

    // Both masters issue reads; always-ready slave answers one cycle after acceptance.
    task automatic run_multi(input int want0_in, input int want1_in);
        int   want [NM];
        bit   resp_next;
        logic prev_cmd;
        bit   finished;
        want[0] = want0_in;
        want[1] = want1_in;
        resp_next = 0;
        prev_cmd  = 1'b0;
        finished  = 0;
        order_q.delete();
        got0_q.delete();
        got1_q.delete();
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge mm_clk);
            for (int i = 0; i < NM; i++) m_read[i] = (want[i] > 0);
            if ((s_read || s_write) && !prev_cmd) order_q.push_back(int'(grant_id));
            prev_cmd = s_read || s_write;
            for (int i = 0; i < NM; i++) begin
                if (!m_waitrequest[i]) want[i]--;
                if (m_readdatavalid[i]) begin
                    if (i == 0) got0_q.push_back(m_readdata[0]);
                    else        got1_q.push_back(m_readdata[1]);
                end
            end
            s_waitrequest = 1'b0;
            if (resp_next && rdata_q.size() > 0) begin
                s_readdatavalid = 1'b1;
                s_readdata      = rdata_q.pop_front();
            end else begin
                s_readdatavalid = 1'b0;
            end
            resp_next = s_read;
            if (want[0] <= 0 && want[1] <= 0 && !busy && !m_readdatavalid[0] && !m_readdatavalid[1]) begin
                finished = 1;
                break;
            end
        end
        m_read          = '0;
        s_readdatavalid = 1'b0;
        s_waitrequest   = 1'b1;
        check_output("multi_finished", 32'(finished), 32'd1);
    endtask

    initial begin
        vecs[0] = '{0, 1'b0, 1'b1, 4'h3, 32'h1234_5678, 4'hF,    2,  0, 32'h0,         3,  0,  4, -1, 32'h0,         0};
        vecs[1] = '{1, 1'b1, 1'b0, 4'h5, 32'h0,         4'hF,    0,  1, 32'hDEAD_BEEF, 0,  1,  2,  4, 32'hDEAD_BEEF, 0};
        vecs[2] = '{0, 1'b0, 1'b1, 4'hA, 32'h0000_BEEF, 4'b0101, 0,  0, 32'h0,         1,  0,  2, -1, 32'h0,         0};
        vecs[3] = '{1, 1'b1, 1'b1, 4'h7, 32'hCAFE_F00D, 4'b0011, 1,  0, 32'h0,         2,  0,  3, -1, 32'h0,         0};
        vecs[4] = '{0, 1'b1, 1'b0, 4'h2, 32'h0,         4'hF,    0, -1, 32'h0,         0,  1,  2, 17, 32'hFFFF_FFFF, 1};
        vecs[5] = '{1, 1'b1, 1'b0, 4'hF, 32'h0,         4'hF,    3,  2, 32'h0000_00A5, 0,  4,  5,  8, 32'h0000_00A5, 1};
        vecs[6] = '{0, 1'b0, 1'b1, 4'h9, 32'h55AA_55AA, 4'b1000, 99, 0, 32'h0,         16, 0, 17, -1, 32'h0,         2};
        vecs[7] = '{1, 1'b1, 1'b0, 4'h1, 32'h0,         4'hF,    99, 0, 32'h0000_1234, 0, 16, 17, 17, 32'hFFFF_FFFF, 3};

        rst             = 1'b1;
        m_address       = '0;
        m_read          = '0;
        m_write         = '0;
        m_writedata     = '0;
        m_byteenable    = '0;
        s_waitrequest   = 1'b1;
        s_readdata      = '0;
        s_readdatavalid = 1'b0;

        repeat (3) @(negedge mm_clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) apply_vector(i, vecs[i]);

        // Simultaneous reads: master 0 wins first, each gets its own word once.
        rdata_q.delete();
        rdata_q.push_back(32'h0000_00A5);
        rdata_q.push_back(32'h0000_005A);
        run_multi(1, 1);
        check_output("sim_order_len", 32'(order_q.size()), 32'd2);
        check_output("sim_got0_len",  32'(got0_q.size()),  32'd1);
        check_output("sim_got1_len",  32'(got1_q.size()),  32'd1);
        if (order_q.size() == 2) begin
            check_output("sim_order0", 32'(order_q[0]), 32'd0);
            check_output("sim_order1", 32'(order_q[1]), 32'd1);
        end
        if (got0_q.size() == 1) check_output("sim_data0", got0_q[0], 32'h0000_00A5);
        if (got1_q.size() == 1) check_output("sim_data1", got1_q[0], 32'h0000_005A);

        // Back-to-back reads from both masters must alternate.
        rdata_q.delete();
        rdata_q.push_back(32'h11);
        rdata_q.push_back(32'h22);
        rdata_q.push_back(32'h33);
        rdata_q.push_back(32'h44);
        run_multi(2, 2);
        check_output("alt_order_len", 32'(order_q.size()), 32'd4);
        if (order_q.size() == 4) begin
            for (int k = 0; k < 4; k++)
                check_output($sformatf("alt_order%0d", k), 32'(order_q[k]), 32'(k % 2));
        end
        check_output("alt_got0_len", 32'(got0_q.size()), 32'd2);
        check_output("alt_got1_len", 32'(got1_q.size()), 32'd2);
        if (got0_q.size() == 2) check_output("alt_data0b", got0_q[1], 32'h33);
        if (got1_q.size() == 2) check_output("alt_data1b", got1_q[1], 32'h44);

        // Reset in READ_WAIT aborts the read silently.
        begin
            bit in_read_wait;
            int spurious;
            in_read_wait = 0;
            spurious     = 0;
            @(negedge mm_clk);
            m_read[0]       = 1'b1;
            s_waitrequest   = 1'b0;
            s_readdatavalid = 1'b0;
            for (int cyc = 0; cyc < 10; cyc++) begin
                @(negedge mm_clk);
                if (!m_waitrequest[0]) begin
                    in_read_wait = 1;
                    break;
                end
            end
            check_output("rstrw_reached", 32'(in_read_wait), 32'd1);
            rst       = 1'b1;
            m_read[0] = 1'b0;
            #1;
            check_reset_outputs("rstrw_async");
            s_readdatavalid = 1'b1;
            s_readdata      = 32'h0BAD_0BAD;
            for (int cyc = 0; cyc < 5; cyc++) begin
                @(negedge mm_clk);
                if (cyc == 1) rst = 1'b0;
                if (cyc == 3) s_readdatavalid = 1'b0;
                if (m_readdatavalid != '0) spurious++;
            end
            check_output("rstrw_no_valid", 32'(spurious), 32'd0);
            check_output("rstrw_busy", 32'(busy), 32'd0);
            check_output("rstrw_timeout_count", 32'(timeout_count), 32'd0);
        end

        // After reset master 0 must win first again.
        rdata_q.delete();
        rdata_q.push_back(32'h77);
        rdata_q.push_back(32'h88);
        run_multi(1, 1);
        if (order_q.size() >= 1) check_output("post_rst_first", 32'(order_q[0]), 32'd0);
        else                     check_output("post_rst_order_len", 32'(order_q.size()), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
